// File: rtl/expr_pkg.sv
// Shared constants and state type for the expression tokenizer.
// Operator token values are the ASCII codes of the operator characters.
package expr_pkg;

  localparam logic [7:0] OP_LPAR  = 8'd40;
  localparam logic [7:0] OP_RPAR  = 8'd41;
  localparam logic [7:0] OP_MUL   = 8'd42;
  localparam logic [7:0] OP_ADD   = 8'd43;

  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [2:0] {
    S_EXPECT = 3'd0,
    S_NUM    = 3'd1,
    S_AFTER  = 3'd2,
    S_FINISH = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

endpackage

// File: rtl/dec_accumulator.sv
// Decimal accumulator for the tokenizer: acc = acc*10 + digit modulo 2^WIDTH,
// plus a sticky unary-minus flag; value is the signed (two's complement) result.
module dec_accumulator #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clear,
  input  logic             digit_en,
  input  logic [3:0]       digit,
  input  logic             neg_en,
  output logic [WIDTH-1:0] value,
  output logic             neg
);

  logic [WIDTH-1:0] acc;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc <= '0;
      neg <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      neg <= 1'b0;
    end else begin
      if (digit_en) acc <= acc * WIDTH'(10) + WIDTH'(digit);
      if (neg_en)   neg <= 1'b1;
    end
  end

  assign value = neg ? (~acc + WIDTH'(1)) : acc;

endmodule

// File: rtl/expr_tokenizer.sv
// Serial ASCII expression tokenizer feeding MathSolver's packed infix array.
// Handshake: char_data is consumed on a rising edge with char_valid && char_ready && !start; char_ready depends only on state.
module expr_tokenizer
  import expr_pkg::*;
#(
  parameter int LEN   = 19,
  parameter int WIDTH = 16,
  localparam int CW   = $clog2(LEN + 1)
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             start,
  input  logic                             char_valid,
  input  logic [7:0]                       char_data,
  output logic                             char_ready,
  output logic [1:0][LEN-1:0][WIDTH-1:0]   infix,
  output logic [CW-1:0]                    token_count,
  output logic                             done,
  output logic                             error,
  output logic [2:0]                       state_dbg
);

  state_t           state, state_nxt;
  logic [CW-1:0]    depth, depth_nxt;
  logic [1:0]       wr_n;
  logic [WIDTH-1:0] val0, val1, num_val, op_val;
  logic             flag0, flag1;
  logic             acc_clear, digit_en, neg_en, neg;
  logic             accept, is_dig, is_term, is_addmul, is_rpar;

  assign char_ready = (state == S_EXPECT) || (state == S_NUM) || (state == S_AFTER);
  assign accept     = char_valid && char_ready && !start;
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERR);
  assign state_dbg  = state;

  assign is_dig    = is_digit(char_data);
  assign is_term   = (char_data == CH_EQ) || (char_data == CH_LF);
  assign is_addmul = (char_data == OP_ADD) || (char_data == OP_MUL);
  assign is_rpar   = (char_data == OP_RPAR);
  assign op_val    = WIDTH'(char_data);

  dec_accumulator #(.WIDTH(WIDTH)) u_acc (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (acc_clear || start),
    .digit_en (digit_en),
    .digit    (char_data[3:0]),
    .neg_en   (neg_en),
    .value    (num_val),
    .neg      (neg)
  );

  always_comb begin
    state_nxt = state;
    depth_nxt = depth;
    wr_n      = 2'd0;
    val0      = '0;
    flag0     = 1'b0;
    val1      = '0;
    flag1     = 1'b0;
    acc_clear = 1'b0;
    digit_en  = 1'b0;
    neg_en    = 1'b0;
    if (accept) begin
      case (state)
        S_EXPECT: begin
          val0  = op_val;
          flag0 = 1'b1;
          if (is_dig) begin
            digit_en  = 1'b1;
            state_nxt = S_NUM;
          end else if (char_data == CH_MINUS && !neg) begin
            neg_en = 1'b1;
          end else if (char_data == OP_LPAR && !neg) begin
            wr_n      = 2'd1;
            depth_nxt = depth + CW'(1);
          end else if (char_data != CH_SPACE) begin
            state_nxt = S_ERR;
          end
        end
        S_NUM: begin
          // The number always lands in the first slot; a trailing operator goes second.
          val0  = num_val;
          val1  = op_val;
          flag1 = 1'b1;
          if (is_dig) begin
            digit_en = 1'b1;
          end else if (is_addmul) begin
            wr_n      = 2'd2;
            acc_clear = 1'b1;
            state_nxt = S_EXPECT;
          end else if (is_rpar && depth != '0) begin
            wr_n      = 2'd2;
            acc_clear = 1'b1;
            depth_nxt = depth - CW'(1);
            state_nxt = S_AFTER;
          end else if (is_term) begin
            wr_n      = 2'd1;
            acc_clear = 1'b1;
            state_nxt = S_FINISH;
          end else if (char_data == CH_SPACE) begin
            wr_n      = 2'd1;
            acc_clear = 1'b1;
            state_nxt = S_AFTER;
          end else begin
            state_nxt = S_ERR;
          end
        end
        S_AFTER: begin
          val0  = op_val;
          flag0 = 1'b1;
          if (is_addmul) begin
            wr_n      = 2'd1;
            state_nxt = S_EXPECT;
          end else if (is_rpar && depth != '0) begin
            wr_n      = 2'd1;
            depth_nxt = depth - CW'(1);
          end else if (is_term) begin
            state_nxt = S_FINISH;
          end else if (char_data != CH_SPACE) begin
            state_nxt = S_ERR;
          end
        end
        default: ;
      endcase
      // A character whose tokens would not all fit writes nothing at all.
      if (({1'b0, token_count} + (CW+1)'(wr_n)) > (CW+1)'(LEN)) begin
        state_nxt = S_ERR;
        wr_n      = 2'd0;
        depth_nxt = depth;
        acc_clear = 1'b0;
      end
    end else if (state == S_FINISH) begin
      state_nxt = (depth == '0) ? S_DONE : S_ERR;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_EXPECT;
      depth       <= '0;
      token_count <= '0;
      infix       <= '0;
    end else if (start) begin
      state       <= S_EXPECT;
      depth       <= '0;
      token_count <= '0;
      infix       <= '0;
    end else begin
      state       <= state_nxt;
      depth       <= depth_nxt;
      token_count <= token_count + CW'(wr_n);
      for (int i = 0; i < LEN; i++) begin
        if (wr_n != 2'd0 && token_count == CW'(i)) begin
          infix[0][i] <= val0;
          infix[1][i] <= WIDTH'(flag0);
        end
        if (wr_n == 2'd2 && (token_count + CW'(1)) == CW'(i)) begin
          infix[0][i] <= val1;
          infix[1][i] <= WIDTH'(flag1);
        end
      end
    end
  end

endmodule

// File: tb/tb_expr_tokenizer.sv
// Randomized and directed bench for expr_tokenizer with a string-level reference model
// and an expected-outcome queue checked by an independent monitor.
module tb_expr_tokenizer;
  import expr_pkg::*;

  localparam int LEN   = 19;
  localparam int WIDTH = 16;
  localparam int CW    = $clog2(LEN + 1);
  localparam int MODV  = 1 << WIDTH;

  logic                           CLK = 1'b0;
  logic                           RST = 1'b1;
  logic                           start = 1'b0;
  logic                           char_valid = 1'b0;
  logic [7:0]                     char_data = 8'h00;
  logic                           char_ready;
  logic [1:0][LEN-1:0][WIDTH-1:0] infix;
  logic [CW-1:0]                  token_count;
  logic                           done, error;
  logic [2:0]                     state_dbg;

  typedef struct packed {
    logic                           done;
    logic                           error;
    logic [CW-1:0]                  cnt;
    logic [1:0][LEN-1:0][WIDTH-1:0] infix;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 CLK = ~CLK;

  expr_tokenizer #(.LEN(LEN), .WIDTH(WIDTH)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .char_valid  (char_valid),
    .char_data   (char_data),
    .char_ready  (char_ready),
    .infix       (infix),
    .token_count (token_count),
    .done        (done),
    .error       (error),
    .state_dbg   (state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal text to WIDTH-bit two's complement, with wrap.
  function automatic int numval(input string d, input bit ng);
    int a = 0;
    for (int j = 0; j < d.len(); j++) a = (a * 10 + (int'(d[j]) - 48)) % MODV;
    if (ng) a = (MODV - a) % MODV;
    return a;
  endfunction

  // Reference: scan the text, collect tokens in queues, report the final outcome.
  function automatic exp_t model(input string s);
    exp_t       r;
    int         vals[$];
    bit         ops[$];
    int         gv[$];
    bit         gf[$];
    int         depth = 0;
    bit         want = 1'b1;
    bit         neg = 1'b0;
    bit         ok = 1'b0;
    bit         bad = 1'b0;
    string      num = "";
    logic [7:0] c;
    bit         dig, term;
    r = '0;
    for (int k = 0; k < s.len() && !ok && !bad; k++) begin
      c    = s[k];
      dig  = (c >= 8'h30) && (c <= 8'h39);
      term = (c == 8'h3D) || (c == 8'h0A);
      gv.delete();
      gf.delete();
      if (num.len() > 0) begin
        if (dig) num = $sformatf("%s%c", num, c);
        else begin
          gv.push_back(numval(num, neg)); gf.push_back(1'b0);
          if (c == 8'h2B || c == 8'h2A) begin
            gv.push_back(int'(c)); gf.push_back(1'b1); want = 1'b1;
          end else if (c == 8'h29 && depth > 0) begin
            gv.push_back(41); gf.push_back(1'b1); depth--; want = 1'b0;
          end else if (term) ok = 1'b1;
          else if (c == 8'h20) want = 1'b0;
          else bad = 1'b1;
          num = "";
          neg = 1'b0;
        end
      end else if (want) begin
        if (dig) num = $sformatf("%c", c);
        else if (c == 8'h2D && !neg) neg = 1'b1;
        else if (c == 8'h28 && !neg) begin gv.push_back(40); gf.push_back(1'b1); depth++; end
        else if (c != 8'h20) bad = 1'b1;
      end else begin
        if (c == 8'h2B || c == 8'h2A) begin gv.push_back(int'(c)); gf.push_back(1'b1); want = 1'b1; end
        else if (c == 8'h29 && depth > 0) begin gv.push_back(41); gf.push_back(1'b1); depth--; end
        else if (term) ok = 1'b1;
        else if (c != 8'h20) bad = 1'b1;
      end
      if (!bad && vals.size() + gv.size() > LEN) bad = 1'b1;
      if (!bad) begin
        foreach (gv[j]) begin vals.push_back(gv[j]); ops.push_back(gf[j]); end
      end
    end
    for (int i = 0; i < vals.size(); i++) begin
      r.infix[0][i] = WIDTH'(vals[i]);
      r.infix[1][i] = {{(WIDTH-1){1'b0}}, ops[i]};
    end
    r.cnt   = CW'(vals.size());
    r.done  = ok && !bad && depth == 0;
    r.error = bad || (ok && depth != 0);
    return r;
  endfunction

  function automatic string gen_expr();
    string      s = "";
    int         open = 0;
    int         terms = $urandom_range(1, 7);
    logic [7:0] pool [8] = '{8'h2B, 8'h2A, 8'h29, 8'h2D, 8'h28, 8'h78, 8'h3D, 8'h20};
    for (int t = 0; t < terms; t++) begin
      if (t > 0) s = $sformatf("%s%c", s, ($urandom_range(0, 1) == 1) ? 8'h2B : 8'h2A);
      if ($urandom_range(0, 4) == 0) begin s = $sformatf("%s(", s); open++; end
      if ($urandom_range(0, 3) == 0) s = $sformatf("%s-", s);
      if ($urandom_range(0, 5) == 0) s = $sformatf("%s ", s);
      repeat ($urandom_range(1, 5)) s = $sformatf("%s%0d", s, $urandom_range(0, 9));
      if ($urandom_range(0, 4) == 0) s = $sformatf("%s ", s);
      if (open > 0 && $urandom_range(0, 2) == 0) begin s = $sformatf("%s)", s); open--; end
    end
    while (open > 0 && $urandom_range(0, 3) != 0) begin s = $sformatf("%s)", s); open--; end
    s = $sformatf("%s%c", s, ($urandom_range(0, 1) == 1) ? 8'h3D : 8'h0A);
    if ($urandom_range(0, 5) == 0) s.putc($urandom_range(0, s.len() - 2), pool[$urandom_range(0, 7)]);
    return s;
  endfunction

  // gap < 0: random 0..2 idle cycles before each character; otherwise exactly gap.
  task automatic run_expr(input string s, input int gap, input bit junk_on_start);
    int budget;
    @(negedge CLK);
    start = 1'b1;
    if (junk_on_start) begin char_valid = 1'b1; char_data = 8'h35; end
    @(negedge CLK);
    start = 1'b0;
    char_valid = 1'b0;
    exp_q.push_back(model(s));
    for (int k = 0; k < s.len(); k++) begin
      if (!char_ready) break;
      repeat ((gap < 0) ? $urandom_range(0, 2) : gap) @(negedge CLK);
      char_valid = 1'b1;
      char_data  = s[k];
      @(negedge CLK);
      char_valid = 1'b0;
    end
    budget = 0;
    while (exp_q.size() > 0 && budget < 50) begin
      @(negedge CLK);
      budget++;
    end
    check("outcome_seen", exp_q.size(), 0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic send_raw(input string s);
    for (int k = 0; k < s.len(); k++) begin
      char_valid = 1'b1;
      char_data  = s[k];
      @(negedge CLK);
    end
    char_valid = 1'b0;
  endtask

  // Monitor: compares the whole visible result once per expected outcome.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST && exp_q.size() > 0 && (done || error)) begin
        e = exp_q.pop_front();
        check("done", done, e.done);
        check("error", error, e.error);
        check("token_count", token_count, e.cnt);
        check("char_ready_end", char_ready, 0);
        for (int i = 0; i < LEN; i++) begin
          check($sformatf("val[%0d]", i), infix[0][i], e.infix[0][i]);
          check($sformatf("flag[%0d]", i), infix[1][i], e.infix[1][i]);
        end
      end
    end
  end

  initial begin
    #2;
    check("rst_token_count", token_count, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_char_ready", char_ready, 1);
    check("rst_infix_zero", (infix == '0), 1);
    check("rst_state", state_dbg, S_EXPECT);
    @(negedge CLK);
    RST = 1'b0;

    run_expr("2*3+(10+4+3)*-20+(6+5)=", 0, 1'b0);
    run_expr("65537+1=", 0, 1'b0);
    run_expr("(1+2=)1=", 0, 1'b0);
    // Once in error, further characters are refused and nothing changes.
    send_raw(")1=");
    check("err_hold_error", error, 1);
    check("err_hold_done", done, 0);
    check("err_hold_ready", char_ready, 0);
    check("err_hold_count", token_count, 4);
    run_expr(")=", 0, 1'b0);
    run_expr("1)=", 0, 1'b0);
    run_expr(" 7 * 8 =", 1, 1'b0);
    run_expr("9=", 0, 1'b1);
    run_expr("1+1+1+1+1+1+1+1+1+1=", 0, 1'b0);
    run_expr("1+1+1+1+1+1+1+1+1+1+1=", 0, 1'b0);
    run_expr("--5=", 0, 1'b0);
    run_expr("-(1)=", 0, 1'b0);
    run_expr("- 5*(2 +3) \n", -1, 1'b0);
    run_expr("((4)=", 0, 1'b0);
    run_expr("12a=", 0, 1'b0);

    // Asynchronous reset in the middle of an expression.
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    send_raw("12+3");
    check("pre_rst_count", token_count, 2);
    #2 RST = 1'b1;
    #1;
    check("mid_rst_count", token_count, 0);
    check("mid_rst_infix_zero", (infix == '0), 1);
    check("mid_rst_ready", char_ready, 1);
    check("mid_rst_done", done, 0);
    check("mid_rst_error", error, 0);
    @(negedge CLK);
    RST = 1'b0;
    run_expr("3*4=", -1, 1'b0);

    for (int n = 0; n < 150; n++) run_expr(gen_expr(), -1, ($urandom_range(0, 7) == 0));

    repeat (3) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
